// File: rtl/readout_tx_dynamic_meas_ctrl.sv
// Transmit-side controller for dynamic (early-stop) qubit readout.
// Ramps the tone envelope up, holds the flat top while RX runs trials,
// and ramps down on an RX decision, last trial or watchdog expiry.
// Optional feature macro: READOUT_TX_ABORT_EN (adds abort_in).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   meas_req_in       start request, accepted only while idle
//   finish_trial_in   RX trial window ended (counted while the tone runs)
//   last_trial_in     RX final trial, stop tone
//   decision_fin_in   RX state decided, stop tone
//   abort_in          (READOUT_TX_ABORT_EN) cut short to ramp-down
//   start_count_out   one-cycle pulse launching the RX bin counters
//   tx_en_out         DAC gate, high during ramp-up/drive/ramp-down
//   envelope_addr_out envelope memory address
//   trial_count_out   saturating count of finished trials
//   meas_busy_out     controller not idle
//   meas_done_out     one-cycle completion pulse
//   timeout_out       sticky watchdog flag, cleared by the next request
module readout_tx_dynamic_meas_ctrl #(
    parameter int RAMP_LEN            = 8,
    parameter int ENV_ADDR_WIDTH      = 4,
    parameter int TRIAL_COUNTER_WIDTH = 4,
    parameter int MAX_TRIAL           = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           meas_req_in,
    input  logic                           finish_trial_in,
    input  logic                           last_trial_in,
    input  logic                           decision_fin_in,
`ifdef READOUT_TX_ABORT_EN
    input  logic                           abort_in,
`endif
    output logic                           start_count_out,
    output logic                           tx_en_out,
    output logic [ENV_ADDR_WIDTH-1:0]      envelope_addr_out,
    output logic [TRIAL_COUNTER_WIDTH-1:0] trial_count_out,
    output logic                           meas_busy_out,
    output logic                           meas_done_out,
    output logic                           timeout_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DRIVE,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [ENV_ADDR_WIDTH-1:0] ADDR_LAST =
        ENV_ADDR_WIDTH'(RAMP_LEN - 1);
    localparam logic [TRIAL_COUNTER_WIDTH-1:0] TRIAL_MAX =
        TRIAL_COUNTER_WIDTH'(MAX_TRIAL);

    state_t                           state_q, state_d;
    logic                             pend_q, pend_d;
    logic                             start_q, start_d;
    logic                             tx_q, tx_d;
    logic [ENV_ADDR_WIDTH-1:0]        addr_q, addr_d;
    logic [TRIAL_COUNTER_WIDTH-1:0]   trial_q, trial_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             tmo_q, tmo_d;

    logic in_run;
    logic stop_raw;
    logic abort_act;
    logic wdog;
    logic stop_ev;

    assign in_run   = (state_q == S_UP) || (state_q == S_DRIVE);
    assign stop_raw = last_trial_in | decision_fin_in;

`ifdef READOUT_TX_ABORT_EN
    assign abort_act = abort_in & in_run;
`else
    assign abort_act = 1'b0;
`endif

    // Watchdog fires on a trial beyond the allowed count when RX did not
    // stop on its own; an abort in the same cycle takes precedence.
    assign wdog = in_run & finish_trial_in & (trial_q == TRIAL_MAX)
                & ~stop_raw & ~abort_act;
    assign stop_ev = in_run & (stop_raw | wdog);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            tx_q    <= 1'b0;
            addr_q  <= '0;
            trial_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            tx_q    <= tx_d;
            addr_q  <= addr_d;
            trial_q <= trial_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (meas_req_in) begin
                    state_d = S_UP;
                    pend_d  = 1'b0;
                end
            end
            S_UP: begin
                // A stop seen mid-ramp is remembered so the ramp completes
                // and then skips the flat top.
                if (stop_ev) pend_d = 1'b1;
                if (abort_act) begin
                    state_d = S_DOWN;
                end else if (addr_q == ADDR_LAST) begin
                    state_d = (pend_q || stop_ev) ? S_DOWN : S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (abort_act || stop_ev) state_d = S_DOWN;
            end
            S_DOWN: begin
                if (addr_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        trial_d = trial_q;
        tmo_d   = tmo_q;
        start_d = (state_q == S_IDLE) && (state_d == S_UP);
        tx_d    = (state_d == S_UP) || (state_d == S_DRIVE)
               || (state_d == S_DOWN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);

        // Entering ramp-down keeps the current address for one cycle.
        unique case (state_q)
            S_UP:    if (state_d == S_UP) addr_d = addr_q + 1'b1;
            S_DOWN:  addr_d = (state_d == S_DOWN) ? addr_q - 1'b1 : '0;
            S_DRIVE: addr_d = addr_q;
            default: addr_d = '0;
        endcase

        if (start_d) begin
            trial_d = '0;
            tmo_d   = 1'b0;
        end else if ((in_run || state_q == S_DOWN) && finish_trial_in
                     && (trial_q != '1)) begin
            trial_d = trial_q + 1'b1;
        end

        if (wdog) tmo_d = 1'b1;
    end

    assign start_count_out   = start_q;
    assign tx_en_out         = tx_q;
    assign envelope_addr_out = addr_q;
    assign trial_count_out   = trial_q;
    assign meas_busy_out     = busy_q;
    assign meas_done_out     = done_q;
    assign timeout_out       = tmo_q;

endmodule

// File: tb/tb_readout_tx_dynamic_meas_ctrl.sv
// Self-checking bench for readout_tx_dynamic_meas_ctrl.
// Fixed vector table, directed corner sequences, random run vs model.
module tb_readout_tx_dynamic_meas_ctrl;

    localparam int R   = 4;
    localparam int AW  = 4;
    localparam int TW  = 4;
    localparam int MT  = 10;
    localparam int CMX = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          fin = 1'b0;
    logic          lst = 1'b0;
    logic          dec = 1'b0;
    logic          abt = 1'b0;
    logic          start_o;
    logic          tx_o;
    logic [AW-1:0] addr_o;
    logic [TW-1:0] cnt_o;
    logic          busy_o;
    logic          done_o;
    logic          to_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    readout_tx_dynamic_meas_ctrl #(
        .RAMP_LEN(R),
        .ENV_ADDR_WIDTH(AW),
        .TRIAL_COUNTER_WIDTH(TW),
        .MAX_TRIAL(MT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .meas_req_in(req),
        .finish_trial_in(fin),
        .last_trial_in(lst),
        .decision_fin_in(dec),
`ifdef READOUT_TX_ABORT_EN
        .abort_in(abt),
`endif
        .start_count_out(start_o),
        .tx_en_out(tx_o),
        .envelope_addr_out(addr_o),
        .trial_count_out(cnt_o),
        .meas_busy_out(busy_o),
        .meas_done_out(done_o),
        .timeout_out(to_o)
    );

    // Reference model: measurement phase plus envelope position.
    // phase 0 idle, 1 ramp-up, 2 flat top, 3 ramp-down, 4 done.
    int m_phase = 0;
    int m_addr  = 0;
    int m_cnt   = 0;
    bit m_to    = 0;
    bit m_pend  = 0;
    bit m_start = 0;

    task automatic model_step();
        bit stop;
        bit run;
        bit wd;
        bit ab;
        if (!rst_n) begin
            m_phase = 0; m_addr = 0; m_cnt = 0;
            m_to = 0; m_pend = 0; m_start = 0;
            return;
        end
        m_start = 0;
        run  = (m_phase == 1) || (m_phase == 2);
`ifdef READOUT_TX_ABORT_EN
        ab = run && abt;
`else
        ab = 0;
`endif
        stop = run && (lst || dec);
        wd   = run && fin && (m_cnt == MT) && !lst && !dec && !ab;
        if (m_phase >= 1 && m_phase <= 3 && fin && m_cnt < CMX)
            m_cnt++;
        if (wd) m_to = 1;
        stop = stop || wd;
        case (m_phase)
            0: if (req) begin
                m_phase = 1; m_addr = 0; m_cnt = 0;
                m_to = 0; m_pend = 0; m_start = 1;
            end
            1: begin
                if (stop) m_pend = 1;
                if (ab) m_phase = 3;
                else if (m_addr == R - 1) m_phase = m_pend ? 3 : 2;
                else m_addr++;
            end
            2: if (stop || ab) m_phase = 3;
            3: if (m_addr == 0) m_phase = 4; else m_addr--;
            default: m_phase = 0;
        endcase
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("start", int'(start_o), int'(m_start));
        chk("tx_en", int'(tx_o), int'(m_phase >= 1 && m_phase <= 3));
        chk("addr", int'(addr_o), m_addr);
        chk("busy", int'(busy_o), int'(m_phase != 0));
        chk("done", int'(done_o), int'(m_phase == 4));
        chk("count", int'(cnt_o), m_cnt);
        chk("timeout", int'(to_o), int'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
    endtask

    task automatic cyc(input bit q, input bit f, input bit l,
                       input bit d, input bit a);
        rst_n = 1; req = q; fin = f; lst = l; dec = d; abt = a;
        tick();
        req = 0; fin = 0; lst = 0; dec = 0; abt = 0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (done_o) seen = 1;
        end
        chk(nm, int'(seen), 1);
    endtask

    typedef struct {
        bit rn, q, f, l, d;
        bit e_st, e_tx, e_bz, e_dn;
        int e_ad, e_ct;
        bit e_to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rn, bit q, bit d, bit st, bit tx,
                                bit bz, bit dn, int ad);
        vec_t v;
        v.rn = rn; v.q = q; v.f = 0; v.l = 0; v.d = d;
        v.e_st = st; v.e_tx = tx; v.e_bz = bz; v.e_dn = dn;
        v.e_ad = ad; v.e_ct = 0; v.e_to = 0;
        return v;
    endfunction

    initial begin
        // Early decision in the first flat-top cycle.
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        // Decision during ramp-up: flat top skipped.
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));

        #2;
        foreach (tbl[i]) begin
            rst_n = tbl[i].rn; req = tbl[i].q; fin = tbl[i].f;
            lst = tbl[i].l; dec = tbl[i].d; abt = 0;
            tick();
            chk("v_start", int'(start_o), int'(tbl[i].e_st));
            chk("v_tx", int'(tx_o), int'(tbl[i].e_tx));
            chk("v_busy", int'(busy_o), int'(tbl[i].e_bz));
            chk("v_done", int'(done_o), int'(tbl[i].e_dn));
            chk("v_addr", int'(addr_o), tbl[i].e_ad);
            chk("v_cnt", int'(cnt_o), tbl[i].e_ct);
            chk("v_to", int'(to_o), int'(tbl[i].e_to));
        end

        // Three trials then last_trial on the flat top.
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (3) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        cyc(0, 0, 1, 0, 0);
        chk("t2_count", int'(cnt_o), 3);
        chk("t2_ramp", int'(addr_o), R - 1);
        wait_done("t2_done");
        chk("t2_to", int'(to_o), 0);
        cyc(0, 0, 0, 0, 0);

        // Watchdog: eleventh trial with no stop.
        cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        chk("t4_cnt10", int'(cnt_o), 10);
        chk("t4_to_pre", int'(to_o), 0);
        chk("t4_busy", int'(busy_o), 1);
        cyc(0, 1, 0, 0, 0);
        chk("t4_to", int'(to_o), 1);
        chk("t4_cnt11", int'(cnt_o), 11);
        wait_done("t4_done");
        chk("t4_to_hold", int'(to_o), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t4_to_clr", int'(to_o), 0);
        chk("t4_cnt_clr", int'(cnt_o), 0);

        // Reset mid flat-top, then a request during ramp-down.
        repeat (4) cyc(0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        chk("t5_tx", int'(tx_o), 0);
        chk("t5_busy", int'(busy_o), 0);
        chk("t5_done", int'(done_o), 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t5_nostart", int'(start_o), 0);
        wait_done("t5_done2");
        cyc(1, 0, 0, 0, 0);
        chk("t5_req_done", int'(start_o), 0);
        chk("t5_idle", int'(busy_o), 0);

`ifdef READOUT_TX_ABORT_EN
        // Abort while ramping up at address 2.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_addr2", int'(addr_o), 2);
        cyc(0, 0, 0, 0, 1);
        chk("t6_hold", int'(addr_o), 2);
        cyc(0, 0, 0, 0, 0);
        chk("t6_a1", int'(addr_o), 1);
        cyc(0, 0, 0, 0, 0);
        chk("t6_a0", int'(addr_o), 0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_done", int'(done_o), 1);
        chk("t6_to", int'(to_o), 0);
        cyc(0, 0, 0, 0, 0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            req = ($urandom_range(0, 3) == 0);
            fin = ($urandom_range(0, 2) == 0);
            lst = ($urandom_range(0, 29) == 0);
            dec = ($urandom_range(0, 29) == 0);
`ifdef READOUT_TX_ABORT_EN
            abt = ($urandom_range(0, 39) == 0);
`else
            abt = 0;
`endif
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
